// File: rtl/audio_control_pkg.sv
// Shared constants for the audio channel block: register bit positions, noise LFSR geometry.
// No logic and no latency of its own.
package audio_control_pkg;

    localparam int NUM_CH = 4;
    localparam int VOL_W  = 4;
    localparam int OUT_W  = VOL_W + 2;

    // AUDCx bit positions; volume occupies [VOL_W-1:0]
    localparam int AUDC_NO_POLY5  = 7;
    localparam int AUDC_POLY4_SEL = 6;
    localparam int AUDC_PURE_TONE = 5;
    localparam int AUDC_VOL_ONLY  = 4;

    // AUDCTL bit positions used by this block
    localparam int AUDCTL_POLY9_SEL = 7;
    localparam int AUDCTL_HP_CH1    = 2;
    localparam int AUDCTL_HP_CH2    = 1;

    // LFSR lengths and the zero-based index of the non-MSB tap
    localparam int POLY4_W    = 4;
    localparam int POLY4_TAP  = 2;
    localparam int POLY5_W    = 5;
    localparam int POLY5_TAP  = 2;
    localparam int POLY9_W    = 9;
    localparam int POLY9_TAP  = 3;
    localparam int POLY17_W   = 17;
    localparam int POLY17_TAP = 11;

    function automatic logic xnor_fb(input logic msb, input logic tap);
        return ~(msb ^ tap);
    endfunction

endpackage

// File: rtl/audio_control_poly_counters.sv
// Free-running 4/5/9/17-bit XNOR noise LFSRs; each output is its MSB, one step per enp.
// No backpressure: state advances on every enp cycle, holds otherwise.
module audio_control_poly_counters
    import audio_control_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enp,
    output logic poly4_o,
    output logic poly5_o,
    output logic poly9_o,
    output logic poly17_o
);

    logic [POLY4_W-1:0]  p4_q,  p4_d;
    logic [POLY5_W-1:0]  p5_q,  p5_d;
    logic [POLY9_W-1:0]  p9_q,  p9_d;
    logic [POLY17_W-1:0] p17_q, p17_d;

    // XNOR feedback makes all-zero a legal start state (all-ones is the lockup)
    always_comb begin
        p4_d  = {p4_q[POLY4_W-2:0],   xnor_fb(p4_q[POLY4_W-1],   p4_q[POLY4_TAP])};
        p5_d  = {p5_q[POLY5_W-2:0],   xnor_fb(p5_q[POLY5_W-1],   p5_q[POLY5_TAP])};
        p9_d  = {p9_q[POLY9_W-2:0],   xnor_fb(p9_q[POLY9_W-1],   p9_q[POLY9_TAP])};
        p17_d = {p17_q[POLY17_W-2:0], xnor_fb(p17_q[POLY17_W-1], p17_q[POLY17_TAP])};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p4_q  <= '0;
            p5_q  <= '0;
            p9_q  <= '0;
            p17_q <= '0;
        end else if (enp) begin
            p4_q  <= p4_d;
            p5_q  <= p5_d;
            p9_q  <= p9_d;
            p17_q <= p17_d;
        end
    end

    assign poly4_o  = p4_q[POLY4_W-1];
    assign poly5_o  = p5_q[POLY5_W-1];
    assign poly9_o  = p9_q[POLY9_W-1];
    assign poly17_o = p17_q[POLY17_W-1];

endmodule

// File: rtl/audio_control.sv
// Four audio channels shaped by AUDCx/AUDCTL and polynomial noise; timer pulse -> chVol 1 enp, -> audOut 2 enp.
// No backpressure; all state steps on enp. Optional AUDIO_HIGHPASS_FILTER_EN adds the ch1/ch2 high-pass flops.
module audio_control
    import audio_control_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enp,
    input  logic [7:0]              D,
    input  logic                    Addr1w,
    input  logic                    Addr3w,
    input  logic                    Addr5w,
    input  logic                    Addr7w,
    input  logic                    Addr8w,
    input  logic [NUM_CH-1:0]       Timer,
    input  logic                    rstAudPhase,
    output logic [NUM_CH*VOL_W-1:0] chVol,
    output logic [OUT_W-1:0]        audOut
);

    logic [7:0]              audc_q [NUM_CH];
    logic [7:0]              audc_d [NUM_CH];
    logic                    poly9_sel_q, poly9_sel_d;
    logic [NUM_CH-1:0]       chout_q, chout_d;
    logic [NUM_CH-1:0]       eff;
    logic [NUM_CH*VOL_W-1:0] chvol_q, chvol_d;
    logic [OUT_W-1:0]        audout_q, audout_d;
    logic [NUM_CH-1:0]       wr;
    logic                    poly4, poly5, poly9, poly17, noise;

    audio_control_poly_counters u_poly (
        .clk      (clk),
        .reset    (reset),
        .enp      (enp),
        .poly4_o  (poly4),
        .poly5_o  (poly5),
        .poly9_o  (poly9),
        .poly17_o (poly17)
    );

    assign wr    = {Addr7w, Addr5w, Addr3w, Addr1w};
    assign noise = poly9_sel_q ? poly9 : poly17;

    always_comb begin
        poly9_sel_d = Addr8w ? D[AUDCTL_POLY9_SEL] : poly9_sel_q;
        for (int i = 0; i < NUM_CH; i++) begin
            audc_d[i] = wr[i] ? D : audc_q[i];
        end
    end

    // Channel flip-flops read the registered AUDC, so a same-cycle write affects only later pulses
    always_comb begin
        chout_d = chout_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Timer[i] && !audc_q[i][AUDC_VOL_ONLY] && (audc_q[i][AUDC_NO_POLY5] || poly5)) begin
                if (audc_q[i][AUDC_PURE_TONE]) begin
                    chout_d[i] = ~chout_q[i];
                end else begin
                    chout_d[i] = audc_q[i][AUDC_POLY4_SEL] ? poly4 : noise;
                end
            end
        end
        if (rstAudPhase) begin
            chout_d = '0;
        end
    end

`ifdef AUDIO_HIGHPASS_FILTER_EN
    logic [1:0] hp_en_q, hp_en_d;
    logic [1:0] hp_q, hp_d;

    // Filter flop samples the post-update channel bit, so equal-rate clocks cancel to silence
    always_comb begin
        hp_en_d = Addr8w ? {D[AUDCTL_HP_CH2], D[AUDCTL_HP_CH1]} : hp_en_q;
        hp_d    = hp_q;
        if (Timer[2]) hp_d[0] = chout_d[0];
        if (Timer[3]) hp_d[1] = chout_d[1];
        if (rstAudPhase) hp_d = '0;
    end

    always_comb begin
        eff = chout_q;
        if (hp_en_q[0]) eff[0] = chout_q[0] ^ hp_q[0];
        if (hp_en_q[1]) eff[1] = chout_q[1] ^ hp_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hp_en_q <= '0;
            hp_q    <= '0;
        end else if (enp) begin
            hp_en_q <= hp_en_d;
            hp_q    <= hp_d;
        end
    end
`else
    assign eff = chout_q;
`endif

    always_comb begin
        audout_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chvol_d[i*VOL_W +: VOL_W] = (audc_q[i][AUDC_VOL_ONLY] || eff[i]) ? audc_q[i][VOL_W-1:0]
                                                                              : '0;
            audout_d = audout_d + OUT_W'(chvol_q[i*VOL_W +: VOL_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                audc_q[i] <= '0;
            end
            poly9_sel_q <= 1'b0;
            chout_q     <= '0;
            chvol_q     <= '0;
            audout_q    <= '0;
        end else if (enp) begin
            for (int i = 0; i < NUM_CH; i++) begin
                audc_q[i] <= audc_d[i];
            end
            poly9_sel_q <= poly9_sel_d;
            chout_q     <= chout_d;
            chvol_q     <= chvol_d;
            audout_q    <= audout_d;
        end
    end

    assign chVol  = chvol_q;
    assign audOut = audout_q;

endmodule

// File: tb/tb_audio_control.sv
// Directed bench for audio_control: a behavioural model pushes expected outputs per clock into a
// scoreboard queue that is popped and compared at the following falling edge.
module tb_audio_control;

    logic        clk;
    logic        reset;
    logic        enp;
    logic [7:0]  D;
    logic        Addr1w, Addr3w, Addr5w, Addr7w, Addr8w;
    logic [3:0]  Timer;
    logic        rstAudPhase;
    logic [15:0] chVol;
    logic [5:0]  audOut;

    int    n_cmp = 0;
    int    n_err = 0;
    string tag   = "init";

    logic [21:0] exp_q [$];

    // reference model state
    logic [7:0]  m_audc [4];
    logic        m_p9sel;
    logic [3:0]  m_chout;
    logic [15:0] m_chvol;
    logic [5:0]  m_aud;
    logic [3:0]  m4;
    logic [4:0]  m5;
    logic [8:0]  m9;
    logic [16:0] m17;
`ifdef AUDIO_HIGHPASS_FILTER_EN
    logic [1:0]  m_hpen;
    logic [1:0]  m_hp;
`endif

    audio_control dut (
        .clk         (clk),
        .reset       (reset),
        .enp         (enp),
        .D           (D),
        .Addr1w      (Addr1w),
        .Addr3w      (Addr3w),
        .Addr5w      (Addr5w),
        .Addr7w      (Addr7w),
        .Addr8w      (Addr8w),
        .Timer       (Timer),
        .rstAudPhase (rstAudPhase),
        .chVol       (chVol),
        .audOut      (audOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Model of one rising clock edge, evaluated on the inputs currently applied
    task automatic model_step();
        logic [3:0]  co;
        logic [3:0]  eff;
        logic [15:0] cv;
        logic [5:0]  ao;
        logic        nz;
`ifdef AUDIO_HIGHPASS_FILTER_EN
        logic [1:0]  hp;
`endif
        if (reset) begin
            for (int i = 0; i < 4; i++) m_audc[i] = 8'h00;
            m_p9sel = 1'b0;
            m_chout = 4'h0;
            m_chvol = 16'h0;
            m_aud   = 6'h0;
            m4 = '0; m5 = '0; m9 = '0; m17 = '0;
`ifdef AUDIO_HIGHPASS_FILTER_EN
            m_hpen = 2'b00;
            m_hp   = 2'b00;
`endif
        end else if (enp) begin
            nz = m_p9sel ? m9[8] : m17[16];
            co = m_chout;
            for (int i = 0; i < 4; i++) begin
                if (Timer[i] && !m_audc[i][4] && (m_audc[i][7] || m5[4]))
                    co[i] = m_audc[i][5] ? ~m_chout[i] : (m_audc[i][6] ? m4[3] : nz);
            end
            eff = m_chout;
`ifdef AUDIO_HIGHPASS_FILTER_EN
            hp = m_hp;
            if (Timer[2]) hp[0] = co[0];
            if (Timer[3]) hp[1] = co[1];
            if (m_hpen[0]) eff[0] = m_chout[0] ^ m_hp[0];
            if (m_hpen[1]) eff[1] = m_chout[1] ^ m_hp[1];
            if (rstAudPhase) hp = 2'b00;
            m_hp = hp;
            if (Addr8w) m_hpen = {D[1], D[2]};
`endif
            if (rstAudPhase) co = 4'h0;
            ao = 6'h0;
            for (int i = 0; i < 4; i++) begin
                cv[i*4 +: 4] = (m_audc[i][4] || eff[i]) ? m_audc[i][3:0] : 4'h0;
                ao = ao + {2'b00, m_chvol[i*4 +: 4]};
            end
            m4  = {m4[2:0],   ~(m4[3]   ^ m4[2])};
            m5  = {m5[3:0],   ~(m5[4]   ^ m5[2])};
            m9  = {m9[7:0],   ~(m9[8]   ^ m9[3])};
            m17 = {m17[15:0], ~(m17[16] ^ m17[11])};
            m_chout = co;
            m_chvol = cv;
            m_aud   = ao;
            if (Addr1w) m_audc[0] = D;
            if (Addr3w) m_audc[1] = D;
            if (Addr5w) m_audc[2] = D;
            if (Addr7w) m_audc[3] = D;
            if (Addr8w) m_p9sel = D[7];
        end
    endtask

    task automatic tick();
        logic [21:0] e;
        model_step();
        @(posedge clk);
        exp_q.push_back({m_chvol, m_aud});
        @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, {10'd0, chVol, audOut}, {10'd0, e});
    endtask

    task automatic clr_strobes();
        Addr1w = 0; Addr3w = 0; Addr5w = 0; Addr7w = 0; Addr8w = 0;
    endtask

    // ch 0..3 writes AUDC1..4, ch 4 writes AUDCTL
    task automatic wr(input int ch, input logic [7:0] v);
        D = v;
        Addr1w = (ch == 0); Addr3w = (ch == 1); Addr5w = (ch == 2);
        Addr7w = (ch == 3); Addr8w = (ch == 4);
        tick();
        clr_strobes();
    endtask

    task automatic wr_all(input logic [7:0] v);
        D = v;
        Addr1w = 1; Addr3w = 1; Addr5w = 1; Addr7w = 1;
        tick();
        clr_strobes();
    endtask

    initial begin
        reset = 1; enp = 0; D = 0; Timer = 0; rstAudPhase = 0;
        clr_strobes();
        tag = "reset";
        tick(); tick();
        reset = 0; enp = 1;
        chk("reset_chvol", {16'd0, chVol}, 32'd0);
        chk("reset_audout", {26'd0, audOut}, 32'd0);

        tag = "volonly";
        wr_all(8'h1F);
        tick(); tick();
        chk("vol_sum60", {26'd0, audOut}, 32'd60);
        wr(2, 8'h10);
        tick(); tick();
        chk("vol_sum45", {26'd0, audOut}, 32'd45);

        tag = "tone";
        wr_all(8'h00);
        wr(0, 8'hA8);
        for (int i = 0; i < 40; i++) begin
            Timer = (i % 10 == 0) ? 4'b0001 : 4'b0000;
            tick();
            if (i == 1)  chk("tone_on",   {28'd0, chVol[3:0]}, 32'd8);
            if (i == 2)  chk("tone_aud8", {26'd0, audOut}, 32'd8);
            if (i == 11) chk("tone_off",  {28'd0, chVol[3:0]}, 32'd0);
            if (i == 12) chk("tone_aud0", {26'd0, audOut}, 32'd0);
        end
        Timer = 0;

        tag = "phase";
        Timer = 4'b0001; tick(); Timer = 0; tick();
        chk("phase_pre", {28'd0, chVol[3:0]}, 32'd8);
        Timer = 4'b0001; rstAudPhase = 1; tick();
        Timer = 0; rstAudPhase = 0; tick();
        chk("phase_clr", {28'd0, chVol[3:0]}, 32'd0);
        Timer = 4'b0001; rstAudPhase = 1; tick();
        Timer = 0; rstAudPhase = 0; tick();
        chk("phase_override", {28'd0, chVol[3:0]}, 32'd0);

        tag = "collide";
        Timer = 4'b0001; D = 8'h1F; Addr1w = 1; tick();
        Timer = 0; clr_strobes(); tick();
        wr(0, 8'hA8);
        tick();
        chk("wr_collide", {28'd0, chVol[3:0]}, 32'd8);

        tag = "poly4";
        wr(0, 8'hCF);
        Timer = 4'b0001;
        for (int i = 0; i < 45; i++) tick();
        Timer = 0;

        tag = "noise";
        wr(0, 8'h0F); wr(1, 8'h47); wr(2, 8'h2C); wr(3, 8'h8A);
        for (int i = 0; i < 60; i++) begin
            Timer = 4'($urandom_range(0, 15));
            if (i == 30) begin Addr8w = 1; D = 8'h80; end
            tick();
            Addr8w = 0;
        end
        Timer = 0;

        tag = "hpf";
        wr(1, 8'h00); wr(3, 8'h00); wr(0, 8'hAF); wr(2, 8'hA0); wr(4, 8'h04);
        for (int i = 0; i < 32; i++) begin
            Timer = (i % 4 == 0) ? 4'b0101 : 4'b0000;
            tick();
        end
        Timer = 0;
`ifdef AUDIO_HIGHPASS_FILTER_EN
        chk("hpf_ch1_silent", {28'd0, chVol[3:0]}, 32'd0);
`endif

        tag = "rst_mid";
        wr_all(8'h1F);
        wr(0, 8'hAF);
        for (int i = 0; i < 8; i++) begin
            Timer = i[0] ? 4'hF : 4'h0;
            tick();
        end
        Timer = 4'hF; reset = 1; tick();
        reset = 0; Timer = 0;
        chk("rst_chvol", {16'd0, chVol}, 32'd0);
        chk("rst_audout", {26'd0, audOut}, 32'd0);
        tick(); tick(); tick();
        chk("rst_regs_cleared", {26'd0, audOut}, 32'd0);

        tag = "hold";
        wr_all(8'h15);
        tick(); tick();
        chk("hold_pre", {26'd0, audOut}, 32'd20);
        enp = 0;
        for (int i = 0; i < 20; i++) begin
            Timer = 4'($urandom_range(0, 15));
            Addr1w = 1; D = 8'h1F;
            rstAudPhase = i[0];
            tick();
        end
        clr_strobes(); Timer = 0; rstAudPhase = 0;
        chk("hold_audout", {26'd0, audOut}, 32'd20);
        chk("hold_chvol", {16'd0, chVol}, 32'h5555);
        enp = 1;
        tick(); tick();
        chk("hold_no_write", {26'd0, audOut}, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
